// File: rtl/stoch_im2col_pkg.sv
// Index helpers shared by the stochastic im2col and col2im stages so both use one mapping.
// Pure elaboration-time functions; no logic, no latency, no flow control.
package stoch_im2col_pkg;

    function automatic int out_dim(input int im, input int k, input int pad, input int stride);
        return (im + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int col_row(input int oy, input int ox, input int out_w);
        return ox + oy * out_w;
    endfunction

    function automatic int col_entry(input int ky, input int kx, input int ch,
                                     input int kh, input int kw);
        return kx + ky * kw + ch * kh * kw;
    endfunction

endpackage

// File: rtl/stoch_signed_col2im_pixel.sv
// Signed unscaled stochastic adder for one pixel: folds N p/m pairs into one p/m pair via a saturating residue.
// Latency 1 cycle (registered outputs).
// No backpressure: consumes one bit per stream every clock.
module stoch_signed_col2im_pixel #(
    parameter int N     = 1,
    parameter int RES_W = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [N-1:0] p_i,
    input  logic [N-1:0] m_i,
    output logic         im_p_o,
    output logic         im_m_o
);
    localparam int CW = $clog2(N + 1);
    // Two guard bits keep res + cp - cm and the +/-1 adjustment from overflowing.
    localparam int NW = ((RES_W > CW) ? RES_W : CW) + 2;
    localparam logic signed [NW-1:0] RMAX = NW'((1 << (RES_W - 1)) - 1);
    localparam logic signed [NW-1:0] RMIN = -RMAX;

    logic [CW-1:0]           cp, cm;
    logic signed [NW-1:0]    net, adj;
    logic signed [RES_W-1:0] res_q, res_d;
    logic                    p_q, p_d, m_q, m_d;

    always_comb begin
        cp = '0;
        cm = '0;
        for (int i = 0; i < N; i++) begin
            cp = cp + CW'(p_i[i]);
            cm = cm + CW'(m_i[i]);
        end
        net = NW'(res_q) + $signed(NW'(cp)) - $signed(NW'(cm));
        p_d = 1'b0;
        m_d = 1'b0;
        adj = '0;
        if (net > 0) begin
            p_d = 1'b1;
            adj = net - NW'(1);
        end else if (net < 0) begin
            m_d = 1'b1;
            adj = net + NW'(1);
        end
        if (adj > RMAX) begin
            res_d = $signed(RMAX[RES_W-1:0]);
        end else if (adj < RMIN) begin
            res_d = $signed(RMIN[RES_W-1:0]);
        end else begin
            res_d = $signed(adj[RES_W-1:0]);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            res_q <= '0;
            p_q   <= 1'b0;
            m_q   <= 1'b0;
        end else begin
            res_q <= res_d;
            p_q   <= p_d;
            m_q   <= m_d;
        end
    end

    assign im_p_o = p_q;
    assign im_m_o = m_q;

endmodule

// File: rtl/stoch_signed_col2im.sv
// Folds a signed stochastic column matrix back into image layout, one adder per covered pixel/channel.
// Latency 1 cycle (registered outputs).
// No backpressure: streams advance every clock.
module stoch_signed_col2im
    import stoch_im2col_pkg::*;
#(
    parameter int IM_HEIGHT = 12,
    parameter int IM_WIDTH  = 12,
    parameter int CHANNELS  = 3,
    parameter int KERNEL_H  = 3,
    parameter int KERNEL_W  = 3,
    parameter int PAD_H     = 2,
    parameter int PAD_W     = 2,
    parameter int STRIDE_H  = 1,
    parameter int STRIDE_W  = 1,
    parameter int RES_W     = 4,
    localparam int OUT_H      = out_dim(IM_HEIGHT, KERNEL_H, PAD_H, STRIDE_H),
    localparam int OUT_W      = out_dim(IM_WIDTH, KERNEL_W, PAD_W, STRIDE_W),
    localparam int COL_HEIGHT = OUT_H * OUT_W,
    localparam int COL_WIDTH  = KERNEL_H * KERNEL_W * CHANNELS
) (
    input  logic                                          CLK,
    input  logic                                          nRST,
    input  logic [COL_HEIGHT-1:0][COL_WIDTH-1:0]          col_p,
    input  logic [COL_HEIGHT-1:0][COL_WIDTH-1:0]          col_m,
    output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] im_p,
    output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] im_m
);
    localparam int KK = KERNEL_H * KERNEL_W;

    // True when kernel tap (ky,kx) of some patch lands on image pixel (r,c).
    function automatic logic covers(input int r, input int c, input int ky, input int kx);
        int ty;
        int tx;
        ty = r + PAD_H - ky;
        tx = c + PAD_W - kx;
        return (ty >= 0) && (tx >= 0) && (ty % STRIDE_H == 0) && (tx % STRIDE_W == 0) &&
               (ty / STRIDE_H < OUT_H) && (tx / STRIDE_W < OUT_W);
    endfunction

    // Number of covering taps before tap k: the packed position of tap k in the adder input.
    function automatic int cov_pos(input int r, input int c, input int k);
        int n;
        n = 0;
        for (int j = 0; j < k; j++) begin
            if (covers(r, c, j / KERNEL_W, j % KERNEL_W)) n++;
        end
        return n;
    endfunction

    // Entries that land in padding are intentionally dropped.
    logic unused_pad;
    assign unused_pad = ^{col_p, col_m};

    for (genvar r = 0; r < IM_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < IM_WIDTH; c++) begin : g_col
            for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
                localparam int N = cov_pos(r, c, KK);
                if (N == 0) begin : g_empty
                    assign im_p[r][c][ch] = 1'b0;
                    assign im_m[r][c][ch] = 1'b0;
                end else begin : g_add
                    logic [N-1:0] p_v, m_v;
                    for (genvar k = 0; k < KK; k++) begin : g_tap
                        localparam int KY = k / KERNEL_W;
                        localparam int KX = k % KERNEL_W;
                        if (covers(r, c, KY, KX)) begin : g_hit
                            localparam int OY  = (r + PAD_H - KY) / STRIDE_H;
                            localparam int OX  = (c + PAD_W - KX) / STRIDE_W;
                            localparam int ROW = col_row(OY, OX, OUT_W);
                            localparam int ENT = col_entry(KY, KX, ch, KERNEL_H, KERNEL_W);
                            localparam int POS = cov_pos(r, c, k);
                            assign p_v[POS] = col_p[ROW][ENT];
                            assign m_v[POS] = col_m[ROW][ENT];
                        end
                    end
                    stoch_signed_col2im_pixel #(
                        .N     (N),
                        .RES_W (RES_W)
                    ) u_pix (
                        .CLK    (CLK),
                        .nRST   (nRST),
                        .p_i    (p_v),
                        .m_i    (m_v),
                        .im_p_o (im_p[r][c][ch]),
                        .im_m_o (im_m[r][c][ch])
                    );
                end
            end
        end
    end

endmodule

// File: tb/tb_stoch_signed_col2im.sv
// Bench for stoch_signed_col2im on a 4x4x1 image, 3x3 kernel, pad 1, stride 1, 4-bit residue.
module tb_stoch_signed_col2im;
    localparam int IH = 4, IW = 4, CH = 1, KH = 3, KW = 3, PH = 1, PW = 1, SH = 1, SW = 1;
    localparam int RW = 4;
    localparam int OH = (IH + 2 * PH - KH) / SH + 1;
    localparam int OW = (IW + 2 * PW - KW) / SW + 1;
    localparam int CHT = OH * OW;
    localparam int CWD = KH * KW * CH;
    localparam int NPIX = IH * IW * CH;
    localparam int NCOL = CHT * CWD;
    localparam int RMAXI = (1 << (RW - 1)) - 1;

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    logic [CHT-1:0][CWD-1:0] col_p = '0;
    logic [CHT-1:0][CWD-1:0] col_m = '0;
    logic [IH-1:0][IW-1:0][CH-1:0] im_p, im_m;

    stoch_signed_col2im #(
        .IM_HEIGHT(IH), .IM_WIDTH(IW), .CHANNELS(CH), .KERNEL_H(KH), .KERNEL_W(KW),
        .PAD_H(PH), .PAD_W(PW), .STRIDE_H(SH), .STRIDE_W(SW), .RES_W(RW)
    ) dut (
        .CLK(CLK), .nRST(nRST), .col_p(col_p), .col_m(col_m), .im_p(im_p), .im_m(im_m)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: coverage lists of flat column indices per flat pixel, integer residues.
    int cov[NPIX][$];
    int res[NPIX];
    logic [NPIX-1:0] exp_p, exp_m;

    task automatic check(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > RMAXI) return RMAXI;
        if (v < -RMAXI) return -RMAXI;
        return v;
    endfunction

    task automatic build_cov();
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++)
                for (int c = 0; c < CH; c++)
                    for (int ky = 0; ky < KH; ky++)
                        for (int kx = 0; kx < KW; kx++) begin
                            int r, cc;
                            r  = oy * SH + ky - PH;
                            cc = ox * SW + kx - PW;
                            if (r >= 0 && r < IH && cc >= 0 && cc < IW)
                                cov[(r * IW + cc) * CH + c].push_back(
                                    (ox + oy * OW) * CWD + kx + ky * KW + c * KH * KW);
                        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPIX; i++) res[i] = 0;
        exp_p = '0;
        exp_m = '0;
    endtask

    task automatic model_step(input logic [NCOL-1:0] p, input logic [NCOL-1:0] m);
        for (int i = 0; i < NPIX; i++) begin
            int cp, cm, net;
            cp = 0;
            cm = 0;
            foreach (cov[i][j]) begin
                cp += int'(p[cov[i][j]]);
                cm += int'(m[cov[i][j]]);
            end
            net = res[i] + cp - cm;
            exp_p[i] = (net >= 1);
            exp_m[i] = (net <= -1);
            if (net >= 1) res[i] = clampi(net - 1);
            else if (net <= -1) res[i] = clampi(net + 1);
            else res[i] = 0;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic [NCOL-1:0] p, input logic [NCOL-1:0] m);
        col_p = p;
        col_m = m;
        @(posedge CLK);
        if (nRST) model_step(p, m);
        @(negedge CLK);
    endtask

    task automatic check_model(input string name);
        check({name, "_p"}, im_p, exp_p);
        check({name, "_m"}, im_m, exp_m);
        check({name, "_excl"}, im_p & im_m, '0);
    endtask

    task automatic check_const(input string name, input logic [NPIX-1:0] ep, input logic [NPIX-1:0] em);
        check({name, "_p"}, im_p, ep);
        check({name, "_m"}, im_m, em);
    endtask

    typedef struct {
        logic p_all;
        logic exp00;
        logic exp11;
    } sat_vec_t;

    sat_vec_t tbl[12];
    localparam logic [NCOL-1:0] ONES = '1;
    localparam logic [NCOL-1:0] ZERO = '0;

    initial begin
        logic [NCOL-1:0] pv, mv;
        logic [NPIX-1:0] ip;
        for (int i = 0; i < 12; i++) tbl[i] = '{p_all: (i == 0), exp00: (i < 4), exp11: (i < 8)};
        build_cov();
        model_reset();

        // 1: reset held with all plus bits high
        #2 nRST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            cycle(ONES, ZERO);
            check_const("rst_hold", '0, '0);
        end
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(ZERO, ZERO);
            check_const("rst_release", '0, '0);
        end

        // 2: single kernel-centre pulse reaches pixel (0,0) only
        pv = '0;
        pv[0 * CWD + 4] = 1'b1;
        cycle(pv, ZERO);
        check_const("pulse_on", 16'h0001, '0);
        check_model("pulse_on_mdl");
        cycle(ZERO, ZERO);
        check_const("pulse_off", '0, '0);

        // 3: plus and minus cancel
        for (int i = 0; i < 6; i++) begin
            cycle(ONES, ONES);
            check_const("cancel", '0, '0);
        end
        for (int i = 0; i < 10; i++) cycle(ZERO, ZERO);
        check_model("drain3");

        // 4: overlap and saturation table
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].p_all ? ONES : ZERO, ZERO);
            ip = im_p;
            check("sat_pix00", NPIX'(ip[0]), NPIX'(tbl[i].exp00));
            check("sat_pix11", NPIX'(ip[1 * IW + 1]), NPIX'(tbl[i].exp11));
            check("sat_m", im_m, '0);
            check_model("sat_mdl");
        end
        for (int i = 0; i < 10; i++) cycle(ZERO, ZERO);

        // 5: negative path on pixel (0,1), then reset mid-stream
        cycle(ZERO, ONES);
        for (int i = 0; i < 3; i++) begin
            ip = im_m;
            check("neg_m01", NPIX'(ip[1]), NPIX'(1));
            ip = im_p;
            check("neg_p01", NPIX'(ip[1]), '0);
            check_model("neg_mdl");
            if (i < 2) cycle(ZERO, ZERO);
        end
        #1 nRST = 1'b0;
        model_reset();
        #1 check_const("neg_async_rst", '0, '0);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            cycle(ZERO, ZERO);
            check_const("neg_rst_low", '0, '0);
        end
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(ZERO, ZERO);
            check_const("neg_after_rst", '0, '0);
        end

        // 6: random streams with occasional resets against the model
        for (int n = 0; n < 400; n++) begin
            int dp, dm;
            dp = $urandom_range(0, 4);
            dm = $urandom_range(0, 4);
            for (int b = 0; b < NCOL; b++) begin
                pv[b] = ($urandom_range(0, 3) < dp);
                mv[b] = ($urandom_range(0, 3) < dm);
            end
            if ($urandom_range(0, 99) < 3) begin
                nRST = 1'b0;
                model_reset();
            end else begin
                nRST = 1'b1;
            end
            cycle(pv, mv);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stoch_signed_col2im.md
# stoch_signed_col2im

Inverse of the stochastic signed im2col stage. Takes a column matrix of signed stochastic bitstreams (p/m pairs), one bit per stream per cycle, and folds it back into image layout. Every image pixel/channel receives the sum of all column entries that cover it, computed with a per-pixel signed unscaled stochastic adder that keeps a saturating residue counter. Used on the backward/transposed-convolution path, after the GEMM that consumes im2col output.

## Interface
- `IM_HEIGHT`, default 12: unpadded image rows.
- `IM_WIDTH`, default 12: unpadded image columns.
- `CHANNELS`, default 3: channels.
- `KERNEL_H` / `KERNEL_W`, default 3 / 3: kernel size.
- `PAD_H` / `PAD_W`, default 2 / 2: zero padding on each side.
- `STRIDE_H` / `STRIDE_W`, default 1 / 1: stride.
- `RES_W`, default 4: residue counter width (signed, two's complement).
- Local `OUT_H = (IM_HEIGHT+2*PAD_H-KERNEL_H)/STRIDE_H+1` and `OUT_W` likewise. Local `COL_HEIGHT = OUT_H*OUT_W` and `COL_WIDTH = KERNEL_H*KERNEL_W*CHANNELS`.
- `CLK`, in, 1: clock, rising edge.
- `nRST`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `col_p`, in, `[COL_HEIGHT-1:0][COL_WIDTH-1:0]`: plus-stream bits.
- `col_m`, in, `[COL_HEIGHT-1:0][COL_WIDTH-1:0]`: minus-stream bits.
- `im_p`, out, `[IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0]`: plus-stream image bits.
- `im_m`, out, same width as `im_p`: minus-stream image bits.

## Operation
- Index map, identical to im2col:
  - Column row = `ox + oy*OUT_W`.
  - Column entry = `kx + ky*KERNEL_W + ch*KERNEL_H*KERNEL_W`.
  - The entry covers pixel `(r,c,ch)` with `r = oy*STRIDE_H+ky-PAD_H` and `c = ox*STRIDE_W+kx-PAD_W`.
  - Entries that land in padding are discarded.
- Per pixel, each cycle:
  - `cp` = popcount of the covering `col_p` bits; `cm` = popcount of the covering `col_m` bits.
  - Both counts are at most `KERNEL_H*KERNEL_W`.
  - `net = res + cp - cm`, computed at a width wide enough that it never overflows.
- Output decision:
  - If `net >= 1`: `im_p=1`, `im_m=0`, `res <= sat(net-1)`.
  - If `net <= -1`: `im_p=0`, `im_m=1`, `res <= sat(net+1)`.
  - Otherwise both outputs are 0 and `res <= 0`.
- `sat` clamps to ±(2^(RES_W-1)-1). The value -2^(RES_W-1) is never produced.
- Both outputs are never 1 together.
- A pixel with zero coverage (possible when stride > kernel) has constant 0 outputs and no residue logic.
- Reset: all residues are 0, all `im_p`/`im_m` are 0.

## Timing
- Outputs are registered. `im_*` in cycle t+1 reflects `col_*` sampled at the rising edge ending cycle t. Latency is 1 cycle. No handshake: streams advance every clock.
- Residue and output update on the same edge.
- Reset mid-stream clears residues and outputs asynchronously. The first post-reset edge processes only that cycle's inputs; no carry from before reset.
- Simultaneous equal `cp` and `cm` with `res=0` gives 0/0 output and `res` stays 0.

## Structure
- Shared package `stoch_im2col_pkg` holds:
  - Functions `out_dim(im, k, pad, stride)`, `col_row(oy, ox, out_w)` and `col_entry(ky, kx, ch, kh, kw)`.
  - These are reused by im2col so both blocks share a single index definition.
- Sub-module `stoch_signed_col2im_pixel`:
  - Parameters `N` (coverage count) and `RES_W`.
  - Inputs are `N`-bit p/m vectors; outputs are the registered p/m bits.
  - One instance per pixel/channel, generated with coverage lists computed at elaboration.

## Test plan
Configuration: IM 4x4, CHANNELS 1, K 3x3, PAD 1, STRIDE 1, RES_W 4, so OUT 4x4, COL_HEIGHT 16, COL_WIDTH 9.

1. Hold `nRST` low with all `col_p` = 1 for 5 cycles -> `im_p` and `im_m` stay all 0. Release reset with inputs at 0 -> outputs remain 0.
2. Single pulse: `col_p[0][4]=1` for one cycle (patch (0,0), kernel center, covers pixel (0,0)) -> `im_p[0][0][0]=1` for exactly one cycle one edge later; all other outputs 0.
3. Cancellation: all `col_p` and all `col_m` = 1 continuously -> all outputs 0 every cycle.
4. Overlap and saturation: all `col_p`=1 for one cycle, then 0.
   - Pixel (0,0) (coverage 4) -> `im_p`=1 for 4 consecutive cycles, then 0.
   - Pixel (1,1) (coverage 9, net 9, residue clamps 8 -> 7) -> `im_p`=1 for 8 cycles, then 0.
5. Negative path: `col_m` all 1 for one cycle -> pixel (0,1) (coverage 6) gives `im_m`=1 for 6 cycles with `im_p`=0. Assert `nRST` after cycle 3 -> outputs 0 immediately and stay 0 after release.
